// File: rtl/register_file_sb_if.sv
// register_file_sb_if -- bundles the register-file/scoreboard bus.
// Ports (all signals visible through the modports):
//   Writeback : RegWriteW, RDW[4:0], ResultW[31:0]
//   Read      : A1[4:0], A2[4:0] -> RD1[31:0], RD2[31:0]
//   Scoreboard: IssueEn, IssueRd[4:0], ReleaseEn, ReleaseRd[4:0]
//               -> Busy1, Busy2, SbOverflow
// master drives the pipeline side; slave is the register file itself.
interface register_file_sb_if;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        IssueEn;
  logic [4:0]  IssueRd;
  logic        ReleaseEn;
  logic [4:0]  ReleaseRd;
  logic        Busy1;
  logic        Busy2;
  logic        SbOverflow;

  modport master (
    output RegWriteW, RDW, ResultW, A1, A2, IssueEn, IssueRd, ReleaseEn, ReleaseRd,
    input  RD1, RD2, Busy1, Busy2, SbOverflow
  );

  modport slave (
    input  RegWriteW, RDW, ResultW, A1, A2, IssueEn, IssueRd, ReleaseEn, ReleaseRd,
    output RD1, RD2, Busy1, Busy2, SbOverflow
  );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb -- 31 x 32-bit register file (x0 hardwired to zero) with a
// per-register 2-bit outstanding-producer scoreboard.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears registers, counters, flag)
//   bus  : register_file_sb_if.slave (writeback, two read ports, issue/release,
//          Busy1/Busy2 and sticky SbOverflow)
// Optional feature: define RF_WRITE_BYPASS_EN to forward ResultW to a matching
// read port in the same cycle and drop Busy for a producer retiring this edge.
module register_file_sb (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);

  // Entry 0 exists only so reads can index directly; it is never written.
  logic [31:0] r_regs [0:31];
  logic [1:0]  r_cnt  [0:31];
  logic        r_sb_overflow;

  logic [1:0]  w_cnt_d [0:31];
  logic [2:0]  w_sum   [0:31];
  logic [1:0]  w_dec   [0:31];
  logic [2:0]  w_diff  [0:31];
  logic        w_ovf_event;
  logic        w_wr_en;

  assign w_wr_en = bus.RegWriteW && (bus.RDW != 5'd0);

  // Next counter value per register: cnt + inc - dec, saturating at 0 and 3.
  always_comb begin
    w_ovf_event = 1'b0;
    for (int r = 0; r < 32; r++) begin
      w_sum[r]   = 3'd0;
      w_dec[r]   = 2'd0;
      w_diff[r]  = 3'd0;
      w_cnt_d[r] = r_cnt[r];
    end
    for (int r = 1; r < 32; r++) begin
      w_sum[r] = {1'b0, r_cnt[r]} +
                 {2'b00, (bus.IssueEn && (bus.IssueRd == 5'(r)))};
      w_dec[r] = {1'b0, (bus.RegWriteW && (bus.RDW == 5'(r)))} +
                 {1'b0, (bus.ReleaseEn && (bus.ReleaseRd == 5'(r)))};
      w_diff[r] = w_sum[r] - {1'b0, w_dec[r]};
      if (w_sum[r] < {1'b0, w_dec[r]}) begin
        w_cnt_d[r]  = 2'd0;
        w_ovf_event = 1'b1;
      end else if (w_diff[r] > 3'd3) begin
        w_cnt_d[r]  = 2'd3;
        w_ovf_event = 1'b1;
      end else begin
        w_cnt_d[r] = w_diff[r][1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        r_regs[r] <= 32'd0;
        r_cnt[r]  <= 2'd0;
      end
      r_sb_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_regs[bus.RDW] <= bus.ResultW;
      end
      for (int r = 1; r < 32; r++) begin
        r_cnt[r] <= w_cnt_d[r];
      end
      if (w_ovf_event) begin
        r_sb_overflow <= 1'b1;
      end
    end
  end

  logic w_busy1_raw;
  logic w_busy2_raw;

  assign w_busy1_raw = (bus.A1 != 5'd0) && (r_cnt[bus.A1] != 2'd0);
  assign w_busy2_raw = (bus.A2 != 5'd0) && (r_cnt[bus.A2] != 2'd0);

`ifdef RF_WRITE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;

  // Bypass is suppressed during reset so reads stay zero.
  assign w_hit1 = !rst && w_wr_en && (bus.RDW == bus.A1);
  assign w_hit2 = !rst && w_wr_en && (bus.RDW == bus.A2);

  assign bus.RD1 = w_hit1 ? bus.ResultW : ((bus.A1 == 5'd0) ? 32'd0 : r_regs[bus.A1]);
  assign bus.RD2 = w_hit2 ? bus.ResultW : ((bus.A2 == 5'd0) ? 32'd0 : r_regs[bus.A2]);

  // The last producer is retiring this edge: the forwarded value is final.
  assign bus.Busy1 = w_busy1_raw &&
                     !(w_hit1 && (r_cnt[bus.A1] == 2'd1) && (w_cnt_d[bus.A1] == 2'd0));
  assign bus.Busy2 = w_busy2_raw &&
                     !(w_hit2 && (r_cnt[bus.A2] == 2'd1) && (w_cnt_d[bus.A2] == 2'd0));
`else
  assign bus.RD1   = (bus.A1 == 5'd0) ? 32'd0 : r_regs[bus.A1];
  assign bus.RD2   = (bus.A2 == 5'd0) ? 32'd0 : r_regs[bus.A2];
  assign bus.Busy1 = w_busy1_raw;
  assign bus.Busy2 = w_busy2_raw;
`endif

  assign bus.SbOverflow = r_sb_overflow;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb -- scoreboard bench for register_file_sb.
// Stimulus is driven one step after each rising edge; the expected outputs for
// that cycle are pushed into a queue and a monitor compares them on the
// falling edge. The reference model keeps plain arrays of register values and
// producer counts.
module tb_register_file_sb;

  logic clk;
  logic rst;

  register_file_sb_if bus ();

  register_file_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  int          checks = 0;
  int          errors = 0;

  // Reference model state.
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_ovf;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'd0;
      m_cnt[r] = 0;
    end
    m_ovf = 1'b0;
  endfunction

  function automatic int next_cnt(input int r, output bit ovf);
    int v;
    v = m_cnt[r];
    if (bus.IssueEn && bus.IssueRd == r) v = v + 1;
    if (bus.RegWriteW && bus.RDW == r) v = v - 1;
    if (bus.ReleaseEn && bus.ReleaseRd == r) v = v - 1;
    ovf = 1'b0;
    if (v > 3) begin
      v = 3;
      ovf = 1'b1;
    end else if (v < 0) begin
      v = 0;
      ovf = 1'b1;
    end
    return v;
  endfunction

  function automatic void read_port(input logic [4:0] a, output logic [31:0] rd,
                                    output logic busy);
    bit dummy;
    rd   = (a == 0) ? 32'd0 : m_mem[a];
    busy = !rst && (a != 0) && (m_cnt[a] != 0);
`ifdef RF_WRITE_BYPASS_EN
    if (!rst && bus.RegWriteW && bus.RDW != 0 && bus.RDW == a) begin
      rd = bus.ResultW;
      if (m_cnt[a] == 1 && next_cnt(int'(a), dummy) == 0) busy = 1'b0;
    end
`else
    dummy = 1'b0;
`endif
  endfunction

  function automatic void push_expect(input string tag);
    exp_t e;
    read_port(bus.A1, e.rd1, e.busy1);
    read_port(bus.A2, e.rd2, e.busy2);
    e.ovf = m_ovf;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  function automatic void model_edge();
    int nc [32];
    bit o;
    if (rst) return;
    for (int r = 1; r < 32; r++) begin
      nc[r] = next_cnt(r, o);
      if (o) m_ovf = 1'b1;
    end
    for (int r = 1; r < 32; r++) m_cnt[r] = nc[r];
    if (bus.RegWriteW && bus.RDW != 0) m_mem[bus.RDW] = bus.ResultW;
  endfunction

  function automatic void set_in(input bit rw, input logic [4:0] rdw, input logic [31:0] res,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input bit ie, input logic [4:0] ird,
                                 input bit re, input logic [4:0] rrd);
    bus.RegWriteW = rw;
    bus.RDW       = rdw;
    bus.ResultW   = res;
    bus.A1        = a1;
    bus.A2        = a2;
    bus.IssueEn   = ie;
    bus.IssueRd   = ird;
    bus.ReleaseEn = re;
    bus.ReleaseRd = rrd;
  endfunction

  // Called just after a rising edge; inputs hold for one full cycle.
  task automatic step(input string tag);
    push_expect(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input bit rw, input logic [4:0] rdw,
                     input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2,
                     input bit ie, input logic [4:0] ird, input bit re, input logic [4:0] rrd);
    set_in(rw, rdw, res, a1, a2, ie, ird, re, rrd);
    step(tag);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  function automatic void cmp32(input string tag, input string f, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h at %0t", tag, f, act, req, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp32(e.tag, "RD1", bus.RD1, e.rd1);
        cmp32(e.tag, "RD2", bus.RD2, e.rd2);
        cmp32(e.tag, "Busy1", 32'(bus.Busy1), 32'(e.busy1));
        cmp32(e.tag, "Busy2", 32'(bus.Busy2), 32'(e.busy2));
        cmp32(e.tag, "SbOverflow", 32'(bus.SbOverflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst = 1'b1;
    model_reset();
    set_in(1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    step("reset_hold");
    rst = 1'b0;

    // Write x5, read back; x0 write ignored.
    cyc("wr_x5", 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0);
    cyc("rd_x5", 1, 5'd0, 32'h0000_1234, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0);
    cyc("rd_x0", 0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0);

    // Two issues then two writebacks to x7.
    cyc("iss7a", 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, 5'd7, 0, 5'd0);
    cyc("iss7b", 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, 5'd7, 0, 5'd0);
    cyc("wb7a", 1, 5'd7, 32'h7777_0001, 5'd7, 5'd7, 0, 5'd0, 0, 5'd0);
    cyc("wb7b", 1, 5'd7, 32'h7777_0002, 5'd7, 5'd7, 0, 5'd0, 0, 5'd0);
    cyc("idle7", 0, 5'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0, 0, 5'd0);

    // Same-cycle issue and writeback to x3 with cnt=1.
    cyc("iss3", 0, 5'd0, 32'h0, 5'd3, 5'd3, 1, 5'd3, 0, 5'd0);
    cyc("iss_wb3", 1, 5'd3, 32'h3333_3333, 5'd3, 5'd3, 1, 5'd3, 0, 5'd0);
    cyc("chk3", 0, 5'd0, 32'h0, 5'd3, 5'd3, 0, 5'd0, 0, 5'd0);

    // Bypass / old-value read of x4.
    cyc("wr4old", 1, 5'd4, 32'h0404_0404, 5'd4, 5'd4, 0, 5'd0, 0, 5'd0);
    cyc("byp4", 1, 5'd4, 32'hA5A5_A5A5, 5'd1, 5'd4, 0, 5'd0, 0, 5'd0);

    // Overflow on x9, then release three times.
    for (int i = 0; i < 4; i++) cyc("iss9", 0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9, 0, 5'd0);
    for (int i = 0; i < 3; i++) cyc("rel9", 0, 5'd0, 32'h0, 5'd9, 5'd0, 0, 5'd0, 1, 5'd9);
    cyc("chk9", 0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0, 0, 5'd0);

    // Underflow and async reset mid-cycle with x5 written and cnt[5]=2.
    rst = 1'b1;
    model_reset();
    step("sync_rst");
    rst = 1'b0;
    cyc("rel_under", 0, 5'd0, 32'h0, 5'd8, 5'd8, 0, 5'd0, 1, 5'd8);
    cyc("w5", 1, 5'd5, 32'hCAFE_0005, 5'd5, 5'd5, 1, 5'd5, 0, 5'd0);
    cyc("i5", 0, 5'd0, 32'h0, 5'd5, 5'd5, 1, 5'd5, 0, 5'd0);
    cyc("i5b", 0, 5'd0, 32'h0, 5'd5, 5'd5, 1, 5'd5, 0, 5'd0);
    set_in(1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1, 5'd5, 0, 5'd0);
    #2;
    rst = 1'b1;
    model_reset();
    push_expect("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst", 0, 5'd0, 32'h0, 5'd5, 5'd5, 0, 5'd0, 0, 5'd0);

    // Randomised traffic on a small register window to force collisions.
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 2, 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        model_reset();
        step("rand_rst");
        rst = 1'b0;
      end else begin
        step("rand");
      end
    end

    set_in(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst (1 = reset).
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 RegWriteW  input  1  writeback write enable.
REQ-005 RDW  input  5  writeback destination register.
REQ-006 ResultW  input  32  writeback data.
REQ-007 A1, A2  input  5 each  decode-stage read addresses.
REQ-008 RD1, RD2  output  32 each  read data for A1, A2.
REQ-009 IssueEn  input  1  a register-writing instruction leaves decode this cycle.
REQ-010 IssueRd  input  5  destination of the issuing instruction.
REQ-011 ReleaseEn  input  1  a squashed in-flight producer is retired without writing.
REQ-012 ReleaseRd  input  5  destination of the squashed producer.
REQ-013 Busy1, Busy2  output  1 each  A1/A2 has an outstanding producer.
REQ-014 SbOverflow  output  1  sticky error flag.

Function
REQ-015 Storage SHALL be 31 x 32-bit registers x1..x31; x0 SHALL read 0 and ignore writes.
REQ-016 Writes SHALL occur on the rising clk edge when RegWriteW=1 and RDW!=0.
REQ-017 RD1/RD2 SHALL be combinational from A1/A2 with zero-cycle latency.
REQ-018 Each of x1..x31 SHALL have a 2-bit outstanding-producer counter cnt[r].
REQ-019 Per edge, per register r: inc = IssueEn and IssueRd=r; dec = number of (RegWriteW and RDW=r) and (ReleaseEn and ReleaseRd=r), 0..2.
REQ-020 cnt[r] SHALL update to cnt[r]+inc-dec; simultaneous inc and one dec SHALL leave cnt unchanged.
REQ-021 Events addressing r=0 SHALL be ignored; cnt for x0 does not exist.
REQ-022 An increment from cnt=3 SHALL hold cnt at 3 and set SbOverflow.
REQ-023 A decrement below 0 (underflow) SHALL hold cnt at 0 and set SbOverflow.
REQ-024 SbOverflow SHALL stay 1 until reset.
REQ-025 Busy1 SHALL be (A1!=0 and cnt[A1]!=0); Busy2 likewise for A2; both are combinational from the current counter state.
REQ-026 In the same cycle that cnt[r] is decremented from 1 to 0, Busy for r SHALL still read 1; it reads 0 from the next cycle.

Reset
REQ-027 rst=1 SHALL immediately clear all registers, all counters and SbOverflow, independent of clk.
REQ-028 During reset, RD1/RD2 SHALL read 0, Busy1/Busy2 SHALL read 0, and all writes/issues SHALL be ignored.
REQ-029 Reset deassertion mid-pipeline SHALL leave the state zero; the first edge after deassertion SHALL be processed normally.

Configuration
REQ-030 With macro RF_WRITE_BYPASS_EN defined: if RegWriteW=1, RDW!=0 and RDW=A1 (or A2), RD1 (RD2) SHALL return ResultW in the same cycle, and the matching Busy SHALL be 0 if cnt=1 and that cnt is being decremented.
REQ-031 Without RF_WRITE_BYPASS_EN: reads SHALL return the pre-edge stored value, and Busy SHALL follow REQ-025/026 unchanged.

Verification
REQ-032 Reset, then write x5=0xDEADBEEF; next cycle with A1=5 -> RD1=0xDEADBEEF; write x0=0x1234 -> RD2 (A2=0)=0.
REQ-033 IssueEn with IssueRd=7 for two cycles, then two writebacks to x7 -> A1=7 gives Busy1=1,1,1,0 across cycles 1-4 (cnt 1,2,1,0).
REQ-034 Same-cycle IssueEn to x3 and RegWriteW to x3 with cnt[3]=1 -> cnt stays 1, Busy1 (A1=3) stays 1, x3 updated.
REQ-035 Four issues to x9 with no writeback -> cnt[9]=3 and SbOverflow=1 after the 4th edge; ReleaseEn to x9 three times -> Busy=0, SbOverflow still 1.
REQ-036 With RF_WRITE_BYPASS_EN: RegWriteW=1, RDW=4, ResultW=0xA5A5A5A5, A2=4 -> RD2=0xA5A5A5A5 in the same cycle; without the macro -> RD2=old x4.
REQ-037 Assert rst asynchronously between edges with x5 written and cnt[5]=2 -> RD1 (A1=5)=0 and Busy1=0 before the next edge.
